// File: rtl/prog_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mod_counter_pkg
//  Description : Shared types and constants for the programmable modulus
//                counter (FSM state encoding and direction codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_mod_counter_pkg;

  // RUN advances on enable; HOLD is the halted one-shot state.
  typedef enum logic {
    CNT_RUN  = 1'b0,
    CNT_HOLD = 1'b1
  } cnt_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : prog_mod_counter_pkg
`default_nettype wire

// File: rtl/prog_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mod_counter
//  Description : Runtime-programmable modulus counter with up/down direction,
//                synchronous load, one-shot halt and combinational cascade
//                carry. The modulus is shadowed and only re-sampled on load
//                or on a wrap, so a new modulus starts at a period boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_mod_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dir,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             wrap,
  output logic             done
);

  import prog_mod_counter_pkg::*;

  // Modulus value 0 encodes the full 2**WIDTH range, hence the extra bit.
  localparam logic [WIDTH:0]   FULL_RANGE = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   ONE_X      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] STEP       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  cnt_state_t       state_q, state_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   m_eff;     // current effective modulus
  logic [WIDTH:0]   m_new;     // effective modulus of the modulus input
  logic [WIDTH:0]   inc_x;     // count+1 kept at full width for the compare
  logic             at_term;

  // Terminal detect, next-state selection and cascade carry.
  always_comb begin
    m_eff   = (mod_q == '0)   ? FULL_RANGE : {1'b0, mod_q};
    m_new   = (modulus == '0) ? FULL_RANGE : {1'b0, modulus};
    inc_x   = {1'b0, count_q} + ONE_X;
    at_term = (dir == DIR_UP) ? (inc_x == m_eff) : (count_q == '0);

    count_d = count_q;
    mod_d   = mod_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    done_d  = done_q;

    if (load) begin
      // Out-of-range load values are clamped to the top of the new range.
      if ({1'b0, load_val} >= m_new) begin
        count_d = WIDTH'(m_new - ONE_X);
      end else begin
        count_d = load_val;
      end
      mod_d   = modulus;
      state_d = CNT_RUN;
      done_d  = 1'b0;
    end else if (enable && (state_q == CNT_RUN)) begin
      if (!at_term) begin
        count_d = (dir == DIR_UP) ? WIDTH'(inc_x) : (count_q - STEP);
      end else if (!one_shot) begin
        // Down-wrap lands on the top of the freshly sampled modulus.
        count_d = (dir == DIR_UP) ? '0 : WIDTH'(m_new - ONE_X);
        mod_d   = modulus;
        wrap_d  = 1'b1;
      end else begin
        state_d = CNT_HOLD;
        done_d  = 1'b1;
      end
    end

    carry_out = enable && !rst && (state_q == CNT_RUN) && at_term;
  end

  // State registers with asynchronous clear to the reset image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      mod_q   <= WIDTH'(DEFAULT_MOD);
      state_q <= CNT_RUN;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      mod_q   <= mod_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule : prog_mod_counter
`default_nettype wire

// File: tb/tb_prog_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_mod_counter
//  Description : Directed self-checking bench for prog_mod_counter
//                (WIDTH=8, DEFAULT_MOD=10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       dir;
  logic       one_shot;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] modulus;
  logic [7:0] count;
  logic       carry_out;
  logic       wrap;
  logic       done;

  int checks   = 0;
  int failures = 0;

  prog_mod_counter #(
    .WIDTH       (8),
    .DEFAULT_MOD (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .dir       (dir),
    .one_shot  (one_shot),
    .load      (load),
    .load_val  (load_val),
    .modulus   (modulus),
    .count     (count),
    .carry_out (carry_out),
    .wrap      (wrap),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are then changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // Synchronous load with enable low, leaves load deasserted.
  task automatic do_load(input logic [7:0] v, input logic [7:0] m);
    load     = 1'b1;
    load_val = v;
    modulus  = m;
    enable   = 1'b0;
    tick();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; dir = 1'b0; one_shot = 1'b0;
    load = 1'b0; load_val = 8'd0; modulus = 8'd10;
    tick(); tick();
    settle();
    checks++;
    if (count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (wrap !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_flags got wrap=%b done=%b exp 0 0", wrap, done);
    end
    checks++;
    if (carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
    enable = 1'b0; dir = 1'b1;
    rst = 1'b0;
    tick();
  endtask

  // DEFAULT_MOD=10 counting up for 25 cycles.
  task automatic test_up_wrap();
    int wraps = 0;
    enable = 1'b1; dir = 1'b1; one_shot = 1'b0;
    for (int i = 0; i < 25; i++) begin
      settle();
      checks++;
      if (count !== 8'(i % 10)) begin
        failures++; $display("FAIL up_count[%0d] got=%0d exp=%0d", i, count, i % 10);
      end
      checks++;
      if (carry_out !== ((i % 10) == 9)) begin
        failures++; $display("FAIL up_carry[%0d] got=%b exp=%b", i, carry_out, (i % 10) == 9);
      end
      checks++;
      if (wrap !== ((i % 10) == 0 && i > 0)) begin
        failures++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap, (i % 10) == 0 && i > 0);
      end
      if (wrap === 1'b1) wraps++;
      tick();
    end
    checks++;
    if (wraps != 2) begin failures++; $display("FAIL up_wrap_total got=%0d exp=2", wraps); end
    enable = 1'b0;
  endtask

  // Load 3 / modulus 5, count down 8 cycles, then clamp check.
  task automatic test_load_down();
    logic [7:0] exp_seq [8] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1};
    dir = 1'b0;
    do_load(8'd3, 8'd5);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      checks++;
      if (count !== exp_seq[i]) begin
        failures++; $display("FAIL down_count[%0d] got=%0d exp=%0d", i, count, exp_seq[i]);
      end
      checks++;
      if (carry_out !== (exp_seq[i] == 8'd0)) begin
        failures++; $display("FAIL down_carry[%0d] got=%b exp=%b", i, carry_out, exp_seq[i] == 8'd0);
      end
      checks++;
      if (wrap !== (i == 4)) begin
        failures++; $display("FAIL down_wrap[%0d] got=%b exp=%b", i, wrap, i == 4);
      end
      tick();
    end
    do_load(8'd7, 8'd5);
    settle();
    checks++;
    if (count !== 8'd4) begin failures++; $display("FAIL load_clamp got=%0d exp=4", count); end
  endtask

  // load and enable together: load wins.
  task automatic test_load_priority();
    dir = 1'b1; enable = 1'b1; load = 1'b1; load_val = 8'd2; modulus = 8'd10;
    tick();
    load = 1'b0; enable = 1'b0;
    settle();
    checks++;
    if (count !== 8'd2) begin failures++; $display("FAIL load_priority got=%0d exp=2", count); end
  endtask

  // One-shot with M=4 counting up from 0.
  task automatic test_one_shot();
    dir = 1'b1; one_shot = 1'b1;
    do_load(8'd0, 8'd4);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (count !== 8'(i) || done !== 1'b0 || carry_out !== (i == 3)) begin
        failures++;
        $display("FAIL oneshot_run[%0d] got count=%0d done=%b carry=%b exp %0d 0 %b",
                 i, count, done, carry_out, i, i == 3);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (count !== 8'd3 || done !== 1'b1 || wrap !== 1'b0 || carry_out !== 1'b0) begin
        failures++;
        $display("FAIL oneshot_hold[%0d] got count=%0d done=%b wrap=%b carry=%b exp 3 1 0 0",
                 i, count, done, wrap, carry_out);
      end
      tick();
    end
    do_load(8'd0, 8'd4);
    settle();
    checks++;
    if (count !== 8'd0 || done !== 1'b0) begin
      failures++; $display("FAIL oneshot_reload got count=%0d done=%b exp 0 0", count, done);
    end
    enable = 1'b1;
    tick();
    settle();
    checks++;
    if (count !== 8'd1) begin failures++; $display("FAIL oneshot_resume got=%0d exp=1", count); end
    enable = 1'b0; one_shot = 1'b0;
  endtask

  // Modulus 10 -> 6 at count 4 without load; takes effect after the wrap.
  task automatic test_mod_change();
    logic [7:0] exp_seq [13] = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0,
                                 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    dir = 1'b1;
    do_load(8'd0, 8'd10);
    enable = 1'b1;
    repeat (4) tick();
    modulus = 8'd6;
    for (int i = 0; i < 13; i++) begin
      settle();
      checks++;
      if (count !== exp_seq[i]) begin
        failures++; $display("FAIL modchg_count[%0d] got=%0d exp=%0d", i, count, exp_seq[i]);
      end
      checks++;
      if (carry_out !== (i == 5 || i == 11)) begin
        failures++; $display("FAIL modchg_carry[%0d] got=%b exp=%b", i, carry_out, i == 5 || i == 11);
      end
      tick();
    end
    enable = 1'b0;
  endtask

  // Full range (modulus 0) roll-over and the degenerate M=1 case.
  task automatic test_boundaries();
    logic [7:0] exp_seq [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
    logic       en_pat  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    dir = 1'b1;
    do_load(8'd254, 8'd0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (count !== exp_seq[i] || carry_out !== (i == 1)) begin
        failures++;
        $display("FAIL full_range[%0d] got count=%0d carry=%b exp %0d %b",
                 i, count, carry_out, exp_seq[i], i == 1);
      end
      tick();
    end
    do_load(8'd5, 8'd1);
    for (int i = 0; i < 4; i++) begin
      enable = en_pat[i];
      settle();
      checks++;
      if (count !== 8'd0 || carry_out !== en_pat[i]) begin
        failures++;
        $display("FAIL mod_one[%0d] got count=%0d carry=%b exp 0 %b", i, count, carry_out, en_pat[i]);
      end
      tick();
    end
    enable = 1'b0;
  endtask

  // Asynchronous reset mid-count and while halted.
  task automatic test_async_reset();
    dir = 1'b1; one_shot = 1'b0;
    do_load(8'd0, 8'd12);
    enable = 1'b1;
    repeat (7) tick();
    settle();
    checks++;
    if (count !== 8'd7 || done !== 1'b0) begin
      failures++; $display("FAIL rst_pre got count=%0d done=%b exp 7 0", count, done);
    end
    dir = 1'b0;
    rst = 1'b1;
    settle();
    checks++;
    if (count !== 8'd0 || wrap !== 1'b0 || done !== 1'b0 || carry_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got count=%0d wrap=%b done=%b carry=%b exp 0 0 0 0",
               count, wrap, done, carry_out);
    end
    tick();
    dir = 1'b1;
    rst = 1'b0;
    tick();
    settle();
    checks++;
    if (count !== 8'd1) begin failures++; $display("FAIL rst_resume got=%0d exp=1", count); end

    one_shot = 1'b1;
    do_load(8'd0, 8'd4);
    enable = 1'b1;
    repeat (5) tick();
    settle();
    checks++;
    if (done !== 1'b1 || count !== 8'd3) begin
      failures++; $display("FAIL hold_pre got count=%0d done=%b exp 3 1", count, done);
    end
    rst = 1'b1;
    settle();
    checks++;
    if (count !== 8'd0 || done !== 1'b0) begin
      failures++; $display("FAIL rst_hold got count=%0d done=%b exp 0 0", count, done);
    end
    tick();
    rst = 1'b0;
    tick();
    settle();
    checks++;
    if (count !== 8'd1 || done !== 1'b0) begin
      failures++; $display("FAIL rst_hold_resume got count=%0d done=%b exp 1 0", count, done);
    end
    enable = 1'b0; one_shot = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_load_down();
    test_load_priority();
    test_one_shot();
    test_mod_change();
    test_boundaries();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prog_mod_counter
`default_nettype wire
